// File: rtl/segre_pkg.sv
// Shared types for the memory-port arbiter: FSM states and grant owner.
package segre_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WB,
    ARB_RD,
    ARB_FILL
  } arb_state_e;

  typedef enum logic {
    GRANT_IC,
    GRANT_DC
  } arb_grant_e;

endpackage

// File: rtl/segre_repl_counter.sv
// Round-robin replacement pointer: advances by one on every refill, wraps at 2^INDEX_SIZE.
module segre_repl_counter #(
  parameter int INDEX_SIZE = 2
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  inc_i,
  output logic [INDEX_SIZE-1:0] index_o
);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      index_o <= '0;
    end else if (inc_i) begin
      index_o <= index_o + 1'b1;
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares one memory port between I-cache and D-cache misses; a dirty D-cache victim
// is written back before the refill read. All outputs come straight from flops.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_SIZE     = 32,
  parameter int LANE_SIZE     = 128,
  parameter int IC_INDEX_SIZE = 2,
  parameter int DC_INDEX_SIZE = 2
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic                     ic_miss_i,
  input  logic [ADDR_SIZE-1:0]     ic_addr_i,
  output logic                     ic_fill_o,
  output logic [LANE_SIZE-1:0]     ic_lane_o,
  output logic [IC_INDEX_SIZE-1:0] ic_lru_index_o,
  input  logic                     dc_miss_i,
  input  logic [ADDR_SIZE-1:0]     dc_addr_i,
  input  logic                     dc_wb_i,
  input  logic [ADDR_SIZE-1:0]     dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0]     dc_wb_lane_i,
  output logic                     dc_fill_o,
  output logic [LANE_SIZE-1:0]     dc_lane_o,
  output logic [DC_INDEX_SIZE-1:0] dc_lru_index_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  output logic [LANE_SIZE-1:0]     mem_wr_lane_o,
  input  logic                     mem_ack_i,
  input  logic [LANE_SIZE-1:0]     mem_rd_lane_i,
  output logic                     busy_o
);

  localparam int LANE_BYTES = LANE_SIZE / 8;
  localparam int OFFSET     = $clog2(LANE_BYTES);

  function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] a);
    return {a[ADDR_SIZE-1:OFFSET], {OFFSET{1'b0}}};
  endfunction

  // state_q is the FSM observation point for bound checkers.
  arb_state_e             state_q, state_d;
  arb_grant_e             grant_q, grant_d, last_grant_q;
  logic                   take;
  logic                   mem_hit;
  logic [ADDR_SIZE-1:0]   addr_q, wb_addr_q, addr_src, wb_addr_src;
  logic [LANE_SIZE-1:0]   wb_lane_q, wb_lane_src, rd_lane_q;
  logic                   req_d, we_d, ic_fill_d, dc_fill_d;
  logic [ADDR_SIZE-1:0]   maddr_d;
  logic [LANE_SIZE-1:0]   wlane_d;

  // Handshake: mem_req_o/mem_addr_o/mem_we_o/mem_wr_lane_o stay stable until a cycle with
  // mem_req_o && mem_ack_i; an ack while mem_req_o is low carries no meaning.
  assign mem_hit = mem_req_o && mem_ack_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    take    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (ic_miss_i || dc_miss_i) begin
          take = 1'b1;
          if (ic_miss_i && dc_miss_i) begin
            grant_d = (last_grant_q == GRANT_IC) ? GRANT_DC : GRANT_IC;
          end else if (dc_miss_i) begin
            grant_d = GRANT_DC;
          end else begin
            grant_d = GRANT_IC;
          end
          state_d = (grant_d == GRANT_DC && dc_wb_i) ? ARB_WB : ARB_RD;
        end
      end
      ARB_WB:   if (mem_hit) state_d = ARB_RD;
      ARB_RD:   if (mem_hit) state_d = ARB_FILL;
      ARB_FILL: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    // On the grant cycle the request is built from the live inputs, later from the latches.
    addr_src    = addr_q;
    wb_addr_src = wb_addr_q;
    wb_lane_src = wb_lane_q;
    if (take) begin
      addr_src    = (grant_d == GRANT_DC) ? dc_addr_i : ic_addr_i;
      wb_addr_src = dc_wb_addr_i;
      wb_lane_src = dc_wb_lane_i;
    end

    req_d     = 1'b0;
    we_d      = 1'b0;
    maddr_d   = '0;
    wlane_d   = '0;
    ic_fill_d = 1'b0;
    dc_fill_d = 1'b0;
    unique case (state_d)
      ARB_WB: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        maddr_d = lane_align(wb_addr_src);
        wlane_d = wb_lane_src;
      end
      ARB_RD: begin
        // Leaving the writeback leaves one idle request cycle before the read.
        req_d   = (state_q != ARB_WB);
        maddr_d = lane_align(addr_src);
      end
      ARB_FILL: begin
        ic_fill_d = (grant_q == GRANT_IC);
        dc_fill_d = (grant_q == GRANT_DC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q       <= ARB_IDLE;
      grant_q       <= GRANT_IC;
      last_grant_q  <= GRANT_IC;
      addr_q        <= '0;
      wb_addr_q     <= '0;
      wb_lane_q     <= '0;
      rd_lane_q     <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_lane_o <= '0;
      ic_fill_o     <= 1'b0;
      dc_fill_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_o     <= req_d;
      mem_we_o      <= we_d;
      mem_addr_o    <= maddr_d;
      mem_wr_lane_o <= wlane_d;
      ic_fill_o     <= ic_fill_d;
      dc_fill_o     <= dc_fill_d;
      busy_o        <= (state_d != ARB_IDLE);
      if (take) begin
        grant_q      <= grant_d;
        last_grant_q <= grant_d;
        addr_q       <= addr_src;
        wb_addr_q    <= wb_addr_src;
        wb_lane_q    <= wb_lane_src;
      end
      if (state_q == ARB_RD && mem_hit) begin
        rd_lane_q <= mem_rd_lane_i;
      end
    end
  end

  assign ic_lane_o = rd_lane_q;
  assign dc_lane_o = rd_lane_q;

  segre_repl_counter #(.INDEX_SIZE(IC_INDEX_SIZE)) u_ic_repl (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .inc_i   (ic_fill_o),
    .index_o (ic_lru_index_o)
  );

  segre_repl_counter #(.INDEX_SIZE(DC_INDEX_SIZE)) u_dc_repl (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .inc_i   (dc_fill_o),
    .index_o (dc_lru_index_o)
  );

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: memory responder, fill monitor, expected queues.
module tb_segre_mem_arbiter;

  localparam int AW    = 32;
  localparam int LW    = 128;
  localparam int MW    = 1 + AW + LW;
  localparam int FW    = 2 + 2 + LW;
  localparam int LIMIT = 200;
  localparam logic [LW-1:0] JUNK = {4{32'hDEAD_BEEF}};

  logic          clk_i, rsn_i;
  logic          ic_miss_i, dc_miss_i, dc_wb_i;
  logic [AW-1:0] ic_addr_i, dc_addr_i, dc_wb_addr_i;
  logic [LW-1:0] dc_wb_lane_i;
  logic          ic_fill_o, dc_fill_o;
  logic [LW-1:0] ic_lane_o, dc_lane_o;
  logic [1:0]    ic_lru_index_o, dc_lru_index_o;
  logic          mem_req_o, mem_we_o, mem_ack_i, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wr_lane_o, mem_rd_lane_i;

  int total = 0;
  int bad   = 0;
  int ack_dly = 0;
  bit inject_ack = 1'b0;
  int ic_ptr = 0;
  int dc_ptr = 0;
  logic [MW-1:0] exp_mem_q[$];
  logic [FW-1:0] exp_fill_q[$];

  segre_mem_arbiter dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .ic_miss_i      (ic_miss_i),
    .ic_addr_i      (ic_addr_i),
    .ic_fill_o      (ic_fill_o),
    .ic_lane_o      (ic_lane_o),
    .ic_lru_index_o (ic_lru_index_o),
    .dc_miss_i      (dc_miss_i),
    .dc_addr_i      (dc_addr_i),
    .dc_wb_i        (dc_wb_i),
    .dc_wb_addr_i   (dc_wb_addr_i),
    .dc_wb_lane_i   (dc_wb_lane_i),
    .dc_fill_o      (dc_fill_o),
    .dc_lane_o      (dc_lane_o),
    .dc_lru_index_o (dc_lru_index_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_lane_o  (mem_wr_lane_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rd_lane_i  (mem_rd_lane_i),
    .busy_o         (busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [LW-1:0] lane_of(input logic [AW-1:0] a);
    return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, ~a, a};
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- expected-queue drivers ----------------
  task automatic push_rd(input logic [AW-1:0] a);
    exp_mem_q.push_back({1'b0, align(a), {LW{1'b0}}});
  endtask

  task automatic push_wb(input logic [AW-1:0] a, input logic [LW-1:0] lane);
    exp_mem_q.push_back({1'b1, a, lane});
  endtask

  task automatic push_fill(input bit dc, input logic [AW-1:0] a);
    logic [1:0] idx;
    idx = dc ? 2'(dc_ptr) : 2'(ic_ptr);
    exp_fill_q.push_back({~dc, dc, idx, lane_of(align(a))});
    if (dc) dc_ptr = (dc_ptr + 1) % 4;
    else    ic_ptr = (ic_ptr + 1) % 4;
  endtask

  task automatic wait_fill(input bit dc);
    int n;
    n = 0;
    while (((dc ? dc_fill_o : ic_fill_o) !== 1'b1) && n < LIMIT) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= LIMIT) check("fill_timeout", 256'(dc ? dc_fill_o : ic_fill_o), 256'(1));
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rsn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rsn_i  = 1'b1;
    ic_ptr = 0;
    dc_ptr = 0;
    @(negedge clk_i);
  endtask

  task automatic serve_ic(input logic [AW-1:0] a);
    push_rd(a);
    push_fill(1'b0, a);
    ic_addr_i = a;
    ic_miss_i = 1'b1;
    wait_fill(1'b0);
    ic_miss_i = 1'b0;
    @(negedge clk_i);
  endtask

  // ---------------- memory responder + transaction check ----------------
  initial begin
    int wait_cnt;
    logic [MW-1:0] e;
    wait_cnt      = 0;
    mem_ack_i     = 1'b0;
    mem_rd_lane_i = JUNK;
    forever begin
      @(negedge clk_i);
      mem_ack_i     = 1'b0;
      mem_rd_lane_i = JUNK;
      if (inject_ack) begin
        mem_ack_i = 1'b1;
      end else if (mem_req_o && rsn_i) begin
        if (wait_cnt == ack_dly) begin
          if (exp_mem_q.size() == 0) begin
            check("mem_unexpected", 256'(mem_req_o), 256'(0));
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_txn", 256'({mem_we_o, mem_addr_o, mem_we_o ? mem_wr_lane_o : {LW{1'b0}}}),
                  256'(e));
          end
          mem_ack_i     = 1'b1;
          mem_rd_lane_i = lane_of(mem_addr_o);
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- fill monitor ----------------
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(negedge clk_i);
      if (ic_fill_o || dc_fill_o) begin
        if (exp_fill_q.size() == 0) begin
          check("fill_unexpected", 256'({ic_fill_o, dc_fill_o}), 256'(0));
        end else begin
          e = exp_fill_q.pop_front();
          check("fill", 256'({ic_fill_o, dc_fill_o,
                              dc_fill_o ? dc_lru_index_o : ic_lru_index_o,
                              dc_fill_o ? dc_lane_o : ic_lane_o}), 256'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rsn_i = 1'b0;
    ic_miss_i = 1'b0; dc_miss_i = 1'b0; dc_wb_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0; dc_wb_addr_i = '0; dc_wb_lane_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_ctrl", 256'({mem_req_o, mem_we_o, ic_fill_o, dc_fill_o, busy_o,
                            ic_lru_index_o, dc_lru_index_o}), 256'(0));
    check("rst_addr", 256'(mem_addr_o), 256'(0));
    check("rst_lanes", 256'({mem_wr_lane_o, ic_lane_o}), 256'(0));
    rsn_i = 1'b1;
    @(negedge clk_i);

    // 1: single IC miss, ack three cycles after the request
    ack_dly = 3;
    push_rd(32'h0000_1234);
    push_fill(1'b0, 32'h0000_1234);
    ic_addr_i = 32'h0000_1234;
    ic_miss_i = 1'b1;
    @(negedge clk_i);
    check("t1_req_latency", 256'({mem_req_o, mem_we_o, busy_o}), 256'(3'b101));
    check("t1_addr", 256'(mem_addr_o), 256'(32'h0000_1230));
    wait_fill(1'b0);
    ic_miss_i = 1'b0;
    @(negedge clk_i);
    check("t1_lru_after", 256'(ic_lru_index_o), 256'(1));
    check("t1_idle", 256'({busy_o, ic_fill_o}), 256'(0));

    // 2: simultaneous misses after reset, DC first then IC; next tie goes to DC again
    apply_reset();
    ack_dly = 1;
    for (int r = 0; r < 2; r++) begin
      push_rd(32'h0000_3000 + 32'(r * 16'h100));
      push_fill(1'b1, 32'h0000_3000 + 32'(r * 16'h100));
      push_rd(32'h0000_2000 + 32'(r * 16'h100));
      push_fill(1'b0, 32'h0000_2000 + 32'(r * 16'h100));
      dc_addr_i = 32'h0000_3000 + 32'(r * 16'h100);
      ic_addr_i = 32'h0000_2000 + 32'(r * 16'h100);
      dc_miss_i = 1'b1;
      ic_miss_i = 1'b1;
      wait_fill(1'b1);
      dc_miss_i = 1'b0;
      wait_fill(1'b0);
      ic_miss_i = 1'b0;
      @(negedge clk_i);
    end

    // 3: dirty DC victim: write 0x40, one-cycle gap, read 0x80
    ack_dly = 0;
    push_wb(32'h0000_0040, lane_of(32'hCAFE_0040));
    push_rd(32'h0000_0080);
    push_fill(1'b1, 32'h0000_0080);
    dc_wb_i      = 1'b1;
    dc_wb_addr_i = 32'h0000_0040;
    dc_wb_lane_i = lane_of(32'hCAFE_0040);
    dc_addr_i    = 32'h0000_0080;
    dc_miss_i    = 1'b1;
    @(negedge clk_i);
    check("t3_wb_req", 256'({mem_req_o, mem_we_o}), 256'(2'b11));
    dc_wb_lane_i = '0;
    dc_wb_addr_i = '0;
    @(negedge clk_i);
    check("t3_gap", 256'(mem_req_o), 256'(0));
    @(negedge clk_i);
    check("t3_rd_req", 256'({mem_req_o, mem_we_o}), 256'(2'b10));
    wait_fill(1'b1);
    dc_miss_i = 1'b0;
    dc_wb_i   = 1'b0;
    @(negedge clk_i);

    // 6: ack while idle is ignored; ack in first request cycle gives fill next cycle
    inject_ack = 1'b1;
    repeat (2) @(negedge clk_i);
    inject_ack = 1'b0;
    @(negedge clk_i);
    check("t6_idle_ack", 256'({busy_o, mem_req_o}), 256'(0));
    ack_dly = 0;
    push_rd(32'h0000_0700);
    push_fill(1'b0, 32'h0000_0700);
    ic_addr_i = 32'h0000_0700;
    ic_miss_i = 1'b1;
    @(negedge clk_i);
    check("t6_req", 256'(mem_req_o), 256'(1));
    @(negedge clk_i);
    check("t6_fill_latency", 256'(ic_fill_o), 256'(1));
    ic_miss_i = 1'b0;
    @(negedge clk_i);

    // 4: five IC refills walk the replacement pointer 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      check("t4_lru_idx", 256'(ic_lru_index_o), 256'(i % 4));
      serve_ic(32'h0000_1000 + 32'(i * 32));
    end

    // 5: reset while reading aborts without a fill; service resumes afterwards
    ack_dly   = 20;
    ic_addr_i = 32'h0000_0500;
    ic_miss_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rsn_i = 1'b0;
    #1;
    check("t5_async_clear", 256'({mem_req_o, busy_o}), 256'(0));
    ic_miss_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rsn_i  = 1'b1;
    ic_ptr = 0;
    dc_ptr = 0;
    @(negedge clk_i);
    check("t5_lru_reset", 256'(ic_lru_index_o), 256'(0));
    ack_dly = 1;
    push_rd(32'h0000_0500);
    push_fill(1'b0, 32'h0000_0500);
    ic_miss_i = 1'b1;
    @(negedge clk_i);
    dc_addr_i = 32'h0000_0900;
    dc_miss_i = 1'b1;
    @(negedge clk_i);
    dc_miss_i = 1'b0;
    wait_fill(1'b0);
    ic_miss_i = 1'b0;

    repeat (6) @(negedge clk_i);
    check("mem_q_drained", 256'(exp_mem_q.size()), 256'(0));
    check("fill_q_drained", 256'(exp_fill_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
